// File: rtl/conv_window_gen_pkg.sv
// Shared types for the convolution front end.
// Pixel word, 5x5 and 3x3 operand bundles, and the window index helpers.
package packConv;

    // Pixel / operand word width
    localparam int NBITS = 8;

    // Window geometry: a 5x5 neighbourhood fed by four stored lines plus the live pixel
    localparam int WIN_N = 5;
    localparam int LB_N  = WIN_N - 1;

    typedef logic [NBITS-1:0] regC;

    // Index r*5+c; r=0 is the oldest line, c=0 the oldest column
    typedef regC [0:24] param25;

    // Centre 3x3 of the 5x5 window, same row-major ordering
    typedef regC [0:8] param9;

    // Flat window index of (r,c)
    function automatic int winIdx(input int r, input int c);
        return r * WIN_N + c;
    endfunction

    // Flat 5x5 index of the k-th element of the centre 3x3
    function automatic int centreIdx(input int k);
        return winIdx(k / 3 + 1, k % 3 + 1);
    endfunction

endpackage

// File: rtl/conv_window_gen_line_delay.sv
// One IMG_W-deep image-line delay, addressed by the current column.
// Reading and writing the same column on an accepted pixel turns the
// array into a one-line delay for that column.
module line_delay
    import packConv::*;
#(
    parameter int IMG_W = 32,
    parameter int COL_W = $clog2(IMG_W)
) (
    input  logic             clock,
    input  logic             shiftEn,
    input  logic [COL_W-1:0] col,
    input  regC              wrData,
    output regC              rdData
);

    // Storage for one full image line
    typedef regC line_t [0:IMG_W-1];

    line_t lineMem;

    // The value stored one line ago at this column
    assign rdData = lineMem[col];

    // Replace the column entry with the newer line's pixel on every accepted pixel
    // NOTE: the line storage has no reset; every entry is rewritten before a window can use it.
    always_ff @(posedge clock) begin
        if (shiftEn) begin
            lineMem[col] <= wrData;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 5x5 sliding-window generator.
// Buffers four image lines and presents every window lying entirely inside
// the frame with a valid/ready handshake. Optional macro WIN3_OUT_EN adds
// the centre 3x3 as win3_out.
module conv_window_gen
    import packConv::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   start,
    input  regC    pix_in,
    input  logic   pix_valid,
    output logic   pix_ready,
    output param25 win_out,
    output logic   win_valid,
    input  logic   win_ready,
    output logic   frame_done
`ifdef WIN3_OUT_EN
    ,
    output param9  win3_out
`endif
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    // First column / row at which the whole 5x5 neighbourhood is inside the frame
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WIN_N - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WIN_N - 1);

    logic             accept;
    logic             colLast;
    logic             rowLast;
    logic             winComplete;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Column entering the window: column[0] oldest line .. column[4] live pixel
    regC column [0:WIN_N-1];

    // Stall the stream while a window is waiting; start blocks acceptance outright
    assign pix_ready   = !start && (!win_valid || win_ready);
    assign accept      = pix_valid && pix_ready;
    assign colLast     = (col == COL_LAST);
    assign rowLast     = (row == ROW_LAST);
    assign winComplete = (row >= ROW_FIRST) && (col >= COL_FIRST);

    assign column[WIN_N-1] = pix_in;

    // Chain of four line delays: each reads the older line and stores the newer one
    for (genvar i = 0; i < LB_N; i++) begin : gLine
        line_delay #(
            .IMG_W(IMG_W),
            .COL_W(COL_W)
        ) uLine (
            .clock  (clock),
            .shiftEn(accept),
            .col    (col),
            .wrData (column[i+1]),
            .rdData (column[i])
        );
    end

    // Raster position tracking and end-of-frame pulse
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else if (start) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && colLast && rowLast;
            if (accept) begin
                if (colLast) begin
                    col <= '0;
                    row <= rowLast ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // Window-available flag: raised by a pixel that completes an in-frame window, dropped when taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_valid <= 1'b0;
        end else if (start) begin
            win_valid <= 1'b0;
        end else if (accept && winComplete) begin
            win_valid <= 1'b1;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

    // Window register: shift every row toward c=0 and load the entering column at c=4
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_out <= '0;
        end else if (accept) begin
            for (int r = 0; r < WIN_N; r++) begin
                for (int c = 0; c < WIN_N - 1; c++) begin
                    win_out[winIdx(r, c)] <= win_out[winIdx(r, c + 1)];
                end
                win_out[winIdx(r, WIN_N - 1)] <= column[r];
            end
        end
    end

`ifdef WIN3_OUT_EN
    // Centre 3x3 taps straight off the window register; valid alongside win_valid
    for (genvar k = 0; k < 9; k++) begin : gWin3
        assign win3_out[k] = win_out[centreIdx(k)];
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen with IMG_W=8, IMG_H=6 and pixel value r*8+c.
// Define WIN3_OUT_EN to also exercise the centre 3x3 output.
module tb_conv_window_gen;
    import packConv::*;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int FRAME = IMG_W * IMG_H;
    localparam int MAXCAP = 2 * FRAME;

    logic   clock = 1'b0;
    logic   reset;
    logic   start;
    regC    pix_in;
    logic   pix_valid;
    logic   pix_ready;
    param25 win_out;
    logic   win_valid;
    logic   win_ready;
    logic   frame_done;
`ifdef WIN3_OUT_EN
    param9  win3_out;
`endif

    int vecCount = 0;
    int errCount = 0;

    // Per-pixel capture from stream_pixels
    logic   capReady [0:MAXCAP-1];
    logic   capValid [0:MAXCAP-1];
    logic   capDone  [0:MAXCAP-1];
    param25 capWin   [0:MAXCAP-1];

    conv_window_gen #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .win_out   (win_out),
        .win_valid (win_valid),
        .win_ready (win_ready),
`ifdef WIN3_OUT_EN
        .win3_out  (win3_out),
`endif
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // Reference window completed by pixel (r,c): rows r-4..r, columns c-4..c
    function automatic param25 expWin(input int r, input int c);
        param25 w;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                w[i*5+j] = regC'((r - 4 + i) * IMG_W + (c - 4 + j));
        return w;
    endfunction

    // Feed `count` pixels from frame start with win_ready high, recording outputs after each edge
    task automatic stream_pixels(input int count);
        for (int k = 0; k < count; k++) begin
            start     = 1'b0;
            win_ready = 1'b1;
            pix_valid = 1'b1;
            pix_in    = regC'(k % FRAME);
            @(negedge clock);
            capReady[k] = pix_ready;
            @(posedge clock);
            #1;
            capValid[k] = win_valid;
            capWin[k]   = win_out;
            capDone[k]  = frame_done;
        end
        pix_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start     = 1'b1;
        pix_valid = 1'b0;
        win_ready = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        win_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        vecCount++;
        if (win_valid !== 1'b0) begin errCount++; $display("FAIL reset_win_valid got %b want 0", win_valid); end
        vecCount++;
        if (win_out !== '0) begin errCount++; $display("FAIL reset_win_out got %h want 0", win_out); end
        vecCount++;
        if (frame_done !== 1'b0) begin errCount++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
`ifdef WIN3_OUT_EN
        vecCount++;
        if (win3_out !== '0) begin errCount++; $display("FAIL reset_win3_out got %h want 0", win3_out); end
`endif
        @(negedge clock);
        reset = 1'b0;
        #1;
        vecCount++;
        if (pix_ready !== 1'b1) begin errCount++; $display("FAIL reset_pix_ready got %b want 1", pix_ready); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_streaming();
        int nWin;
        int nDone;
        pulse_start();
        stream_pixels(FRAME);
        nWin  = 0;
        nDone = 0;
        for (int k = 0; k < FRAME; k++) begin
            int  r = k / IMG_W;
            int  c = k % IMG_W;
            logic expV = (r >= 4) && (c >= 4);
            vecCount++;
            if (capReady[k] !== 1'b1) begin errCount++; $display("FAIL stream_pix_ready[%0d] got %b want 1", k, capReady[k]); end
            vecCount++;
            if (capValid[k] !== expV) begin errCount++; $display("FAIL stream_win_valid[%0d] got %b want %b", k, capValid[k], expV); end
            if (expV) begin
                nWin++;
                vecCount++;
                if (capWin[k] !== expWin(r, c)) begin errCount++; $display("FAIL stream_win[%0d] got %h want %h", k, capWin[k], expWin(r, c)); end
            end
            vecCount++;
            if (capDone[k] !== (k == FRAME - 1)) begin errCount++; $display("FAIL stream_frame_done[%0d] got %b want %b", k, capDone[k], k == FRAME - 1); end
            if (capDone[k] === 1'b1) nDone++;
        end
        vecCount++;
        if (capWin[36][0] !== 8'd0 || capWin[36][12] !== 8'd18 || capWin[36][24] !== 8'd36) begin
            errCount++;
            $display("FAIL stream_first_taps got %0d/%0d/%0d want 0/18/36", capWin[36][0], capWin[36][12], capWin[36][24]);
        end
        vecCount++;
        if (nWin != 8) begin errCount++; $display("FAIL stream_window_count got %0d want 8", nWin); end
        vecCount++;
        if (nDone != 1) begin errCount++; $display("FAIL stream_done_count got %0d want 1", nDone); end
        @(posedge clock);
        #1;
        vecCount++;
        if (frame_done !== 1'b0) begin errCount++; $display("FAIL stream_done_pulse_width got %b want 0", frame_done); end
    endtask

    task automatic test_backpressure();
        pulse_start();
        stream_pixels(36);
        pix_valid = 1'b1;
        pix_in    = regC'(36);
        win_ready = 1'b0;
        @(posedge clock);
        #1;
        vecCount++;
        if (win_valid !== 1'b1 || win_out !== expWin(4, 4)) begin
            errCount++;
            $display("FAIL bp_first valid %b win %h want 1 %h", win_valid, win_out, expWin(4, 4));
        end
        pix_in = regC'(37);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vecCount++;
            if (pix_ready !== 1'b0) begin errCount++; $display("FAIL bp_pix_ready[%0d] got %b want 0", i, pix_ready); end
            vecCount++;
            if (win_valid !== 1'b1 || win_out !== expWin(4, 4)) begin
                errCount++;
                $display("FAIL bp_hold[%0d] valid %b win %h want 1 %h", i, win_valid, win_out, expWin(4, 4));
            end
            @(posedge clock);
            #1;
        end
        win_ready = 1'b1;
        @(negedge clock);
        vecCount++;
        if (pix_ready !== 1'b1) begin errCount++; $display("FAIL bp_release_ready got %b want 1", pix_ready); end
        @(posedge clock);
        #1;
        pix_valid = 1'b0;
        vecCount++;
        if (win_valid !== 1'b1 || win_out !== expWin(4, 5)) begin
            errCount++;
            $display("FAIL bp_next valid %b win %h want 1 %h", win_valid, win_out, expWin(4, 5));
        end
        vecCount++;
        if (win_out[24] !== 8'd37) begin errCount++; $display("FAIL bp_next_tap24 got %0d want 37", win_out[24]); end
    endtask

    task automatic test_start();
        int nWin;
        pulse_start();
        stream_pixels(21);
        start     = 1'b1;
        pix_valid = 1'b1;
        pix_in    = 8'hAA;
        win_ready = 1'b1;
        @(negedge clock);
        vecCount++;
        if (pix_ready !== 1'b0) begin errCount++; $display("FAIL start_pix_ready got %b want 0", pix_ready); end
        @(posedge clock);
        #1;
        start     = 1'b0;
        pix_valid = 1'b0;
        vecCount++;
        if (win_valid !== 1'b0) begin errCount++; $display("FAIL start_win_valid got %b want 0", win_valid); end
        stream_pixels(FRAME);
        nWin = 0;
        for (int k = 0; k < FRAME; k++) begin
            int  r = k / IMG_W;
            int  c = k % IMG_W;
            logic expV = (r >= 4) && (c >= 4);
            vecCount++;
            if (capValid[k] !== expV) begin errCount++; $display("FAIL start_win_valid[%0d] got %b want %b", k, capValid[k], expV); end
            if (expV) begin
                nWin++;
                vecCount++;
                if (capWin[k] !== expWin(r, c)) begin errCount++; $display("FAIL start_win[%0d] got %h want %h", k, capWin[k], expWin(r, c)); end
            end
        end
        vecCount++;
        if (nWin != 8) begin errCount++; $display("FAIL start_window_count got %0d want 8", nWin); end
    endtask

    task automatic test_async_reset();
        int nWin;
        pulse_start();
        stream_pixels(37);
        win_ready = 1'b0;
        vecCount++;
        if (win_valid !== 1'b1) begin errCount++; $display("FAIL areset_pre_valid got %b want 1", win_valid); end
        #2;
        reset = 1'b1;
        #1;
        vecCount++;
        if (win_valid !== 1'b0) begin errCount++; $display("FAIL areset_win_valid got %b want 0", win_valid); end
        vecCount++;
        if (win_out !== '0) begin errCount++; $display("FAIL areset_win_out got %h want 0", win_out); end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        stream_pixels(FRAME);
        nWin = 0;
        for (int k = 0; k < FRAME; k++) begin
            int  r = k / IMG_W;
            int  c = k % IMG_W;
            logic expV = (r >= 4) && (c >= 4);
            vecCount++;
            if (capValid[k] !== expV) begin errCount++; $display("FAIL areset_win_valid[%0d] got %b want %b", k, capValid[k], expV); end
            if (expV) begin
                nWin++;
                vecCount++;
                if (capWin[k] !== expWin(r, c)) begin errCount++; $display("FAIL areset_win[%0d] got %h want %h", k, capWin[k], expWin(r, c)); end
            end
        end
        vecCount++;
        if (nWin != 8) begin errCount++; $display("FAIL areset_window_count got %0d want 8", nWin); end
    endtask

`ifdef WIN3_OUT_EN
    task automatic test_win3();
        param9 exp3;
        exp3 = {8'd9, 8'd10, 8'd11, 8'd17, 8'd18, 8'd19, 8'd25, 8'd26, 8'd27};
        pulse_start();
        stream_pixels(37);
        vecCount++;
        if (win3_out !== exp3) begin errCount++; $display("FAIL win3_first got %h want %h", win3_out, exp3); end
    endtask
`endif

    task automatic test_back_to_back();
        param25 wins [$];
        pulse_start();
        stream_pixels(MAXCAP);
        for (int k = 0; k < MAXCAP; k++) begin
            int  p = k % FRAME;
            int  r = p / IMG_W;
            int  c = p % IMG_W;
            logic expV = (r >= 4) && (c >= 4);
            vecCount++;
            if (capValid[k] !== expV) begin errCount++; $display("FAIL b2b_win_valid[%0d] got %b want %b", k, capValid[k], expV); end
            if (capValid[k] === 1'b1) begin
                wins.push_back(capWin[k]);
                if (expV) begin
                    vecCount++;
                    if (capWin[k] !== expWin(r, c)) begin errCount++; $display("FAIL b2b_win[%0d] got %h want %h", k, capWin[k], expWin(r, c)); end
                end
            end
            vecCount++;
            if (capDone[k] !== (p == FRAME - 1)) begin errCount++; $display("FAIL b2b_frame_done[%0d] got %b want %b", k, capDone[k], p == FRAME - 1); end
        end
        vecCount++;
        if (wins.size() != 16) begin
            errCount++;
            $display("FAIL b2b_window_count got %0d want 16", wins.size());
        end else begin
            vecCount++;
            if (wins[8] !== expWin(4, 4)) begin errCount++; $display("FAIL b2b_ninth_window got %h want %h", wins[8], expWin(4, 4)); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_start();
        test_async_reset();
`ifdef WIN3_OUT_EN
        test_win3();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
